// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: one outstanding word fetch, DEPTH-entry {instr, pc} FIFO, redirect flush.
// Define FETCH_WFI_EN to halt fetching after a WFI word until irq or redirect.
//
// state   | meaning
// S_FETCH | request issue enabled
// S_DRAIN | a request is outstanding whose response will be discarded
// S_WFI   | halted after WFI, no requests issued
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        res,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_valid,
  input  logic [31:0] instr_read,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  output logic        wfi_sleep
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_WFI} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx, addr_nx, target;
  logic          req_nx;
  logic [CW-1:0] count, count_after;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [63:0]   mem [DEPTH];
  logic          resp, push, pop, is_wfi;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

`ifdef FETCH_WFI_EN
  localparam logic [31:0] WFI_WORD = 32'h1050_0073;
  assign is_wfi    = (instr_read == WFI_WORD);
  assign wfi_sleep = (state == S_WFI);
`else
  assign is_wfi    = 1'b0;
  assign wfi_sleep = 1'b0;
`endif

  assign target      = {redirect_pc[31:2], 2'b00};
  assign resp        = instr_req & instr_valid;
  assign out_valid   = (count != '0);
  assign pop         = out_valid & out_ready & ~redirect;
  assign push        = resp & ~redirect & (state == S_FETCH);
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_nx      = instr_req;
    addr_nx     = instr_addr;
    unique case (state)
      S_FETCH: begin
        if (redirect) begin
          fetch_pc_nx = target;
          if (instr_req && !instr_valid) begin
            state_nx = S_DRAIN;
          end else begin
            req_nx  = 1'b1;
            addr_nx = target;
          end
        end else if (resp) begin
          fetch_pc_nx = fetch_pc + 32'd4;
          addr_nx     = fetch_pc + 32'd4;
          if (is_wfi) begin
            state_nx = S_WFI;
            req_nx   = 1'b0;
          end else begin
            req_nx = (count_after < FULL);
          end
        end else if (!instr_req) begin
          req_nx  = (count_after < FULL);
          addr_nx = fetch_pc;
        end
      end
      S_DRAIN: begin
        // request and address stay frozen until the stale response arrives
        if (redirect) fetch_pc_nx = target;
        if (instr_valid) begin
          state_nx = S_FETCH;
          req_nx   = 1'b1;
          addr_nx  = fetch_pc_nx;
        end
      end
      S_WFI: begin
        if (redirect) begin
          state_nx    = S_FETCH;
          fetch_pc_nx = target;
          req_nx      = 1'b1;
          addr_nx     = target;
        end else if (irq) begin
          state_nx = S_FETCH;
          req_nx   = (count_after < FULL);
          addr_nx  = fetch_pc;
        end
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= S_FETCH;
      fetch_pc   <= RESET_PC;
      instr_req  <= 1'b0;
      instr_addr <= RESET_PC;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_nx;
      fetch_pc   <= fetch_pc_nx;
      instr_req  <= req_nx;
      instr_addr <= addr_nx;
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_after;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {instr_read, instr_addr};
  end

  assign out_instr = out_valid ? mem[rd_ptr][63:32] : 32'h0;
  assign out_pc    = out_valid ? mem[rd_ptr][31:0]  : 32'h0;
endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: random memory latency, pops, redirects and irqs against a queue-based model.
module tb_instr_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WFI_WORD = 32'h1050_0073;
`ifdef FETCH_WFI_EN
  localparam bit WFI_EN = 1'b1;
`else
  localparam bit WFI_EN = 1'b0;
`endif
  localparam int MD_FETCH = 0, MD_DRAIN = 1, MD_WFI = 2;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        instr_req, instr_valid, out_valid, out_ready, redirect, irq, wfi_sleep;
  logic [31:0] instr_addr, instr_read, out_instr, out_pc, redirect_pc;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .res(res),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_read(instr_read),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .irq(irq), .wfi_sleep(wfi_sleep)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: queue of {instr, pc} plus fetch bookkeeping
  logic [63:0] q[$];
  logic [31:0] m_pc, m_addr;
  logic        m_req;
  int          m_mode;

  // stimulus knobs and memory responder state
  int          lat_min, lat_max, ready_pct, redir_pct, irq_pct, wfi_pct;
  logic [31:0] wfi_addr;
  bit          busy;
  int          wait_c, n_resp, nreq;
  bit          found;

  task automatic model_step();
    logic        resp, pop_ok;
    logic [31:0] tgt;
    resp   = instr_valid && m_req;
    tgt    = {redirect_pc[31:2], 2'b00};
    pop_ok = (q.size() > 0) && out_ready && !redirect;
    if (redirect) begin
      q.delete();
      m_pc = tgt;
      if (m_req && !resp) begin
        m_mode = MD_DRAIN;
      end else begin
        m_mode = MD_FETCH;
        m_req  = 1'b1;
        m_addr = tgt;
      end
    end else begin
      if (pop_ok) void'(q.pop_front());
      if (m_mode == MD_DRAIN) begin
        if (resp) begin
          m_mode = MD_FETCH;
          m_req  = 1'b1;
          m_addr = m_pc;
        end
      end else if (m_mode == MD_WFI) begin
        if (irq) begin
          m_mode = MD_FETCH;
          m_req  = (q.size() < DEPTH);
          m_addr = m_pc;
        end
      end else if (resp) begin
        q.push_back({instr_read, m_addr});
        m_pc = m_addr + 32'd4;
        if (WFI_EN && instr_read == WFI_WORD) begin
          m_mode = MD_WFI;
          m_req  = 1'b0;
        end else begin
          m_req  = (q.size() < DEPTH);
          m_addr = m_pc;
        end
      end else if (!m_req) begin
        m_req  = (q.size() < DEPTH);
        m_addr = m_pc;
      end
    end
  endtask

  task automatic compare();
    chk("req", 32'(instr_req), 32'(m_req));
    if (m_req) chk("addr", instr_addr, m_addr);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_instr", out_instr, q[0][63:32]);
      chk("out_pc", out_pc, q[0][31:0]);
    end
    chk("wfi_sleep", 32'(wfi_sleep), 32'(m_mode == MD_WFI));
  endtask

  task automatic pick_inputs();
    out_ready   = ($urandom_range(0, 99) < ready_pct);
    redirect    = ($urandom_range(0, 99) < redir_pct);
    redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_0FFF);
    irq         = ($urandom_range(0, 99) < irq_pct);
    instr_valid = 1'b0;
    instr_read  = $urandom;
    if (instr_req) begin
      if (!busy) begin
        busy   = 1'b1;
        wait_c = $urandom_range(lat_max, lat_min);
      end
      if (wait_c == 0) begin
        instr_valid = 1'b1;
        busy        = 1'b0;
        n_resp++;
        if (instr_addr == wfi_addr || $urandom_range(0, 99) < wfi_pct) instr_read = WFI_WORD;
      end else begin
        wait_c--;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
    pick_inputs();
  endtask

  task automatic do_reset();
    res         = 1'b0;
    instr_valid = 1'b0;
    instr_read  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    irq         = 1'b0;
    out_ready   = 1'b0;
    busy        = 1'b0;
    wait_c      = 0;
    q.delete();
    m_pc   = RESET_PC;
    m_addr = RESET_PC;
    m_req  = 1'b0;
    m_mode = MD_FETCH;
    #1;
    chk("rst_req", 32'(instr_req), 32'd0);
    chk("rst_addr", instr_addr, RESET_PC);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_sleep", 32'(wfi_sleep), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
  endtask

  initial begin
    lat_min = 0; lat_max = 0; ready_pct = 100; redir_pct = 0; irq_pct = 0; wfi_pct = 0;
    wfi_addr = 32'h1;
    #2;
    do_reset();

    // same-cycle memory, consumer always ready: no bubbles
    nreq = 0;
    repeat (12) begin
      cycle();
      nreq += 32'(instr_req);
    end
    chk("tput_req_cycles", 32'(nreq), 32'd12);
    chk("tput_addr", instr_addr, 32'h2C);
    chk("tput_head_pc", out_pc, 32'h28);

    // consumer stalled: FIFO fills to DEPTH, one pop releases one fetch
    do_reset();
    ready_pct = 0;
    n_resp = 0;
    repeat (8) cycle();
    chk("full_fetches", 32'(n_resp), 32'd4);
    chk("full_req", 32'(instr_req), 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("refill_req", 32'(instr_req), 32'd1);
    chk("refill_addr", instr_addr, 32'h10);

    // redirect while the fetch of 0x8 is outstanding
    do_reset();
    ready_pct = 100; lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (instr_req && !instr_valid && instr_addr == 32'h8) found = 1'b1;
    end
    chk("drain_setup", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    cycle();
    chk("drain_hold_addr", instr_addr, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      chk("drain_empty", 32'(out_valid), 32'd0);
      if (instr_req && instr_addr == 32'h100) found = 1'b1;
    end
    chk("drain_target", 32'(found), 32'd1);

    // redirect coinciding with a response and a pop
    lat_min = 0; lat_max = 0;
    repeat (10) cycle();
    chk("rv_setup", 32'(out_valid & instr_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0202;
    cycle();
    chk("rv_req", 32'(instr_req), 32'd1);
    chk("rv_addr", instr_addr, 32'h200);
    chk("rv_empty", 32'(out_valid), 32'd0);

    // address wrap
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    chk("wrap_first", instr_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_next", instr_addr, 32'h0000_0000);

    // WFI word at 0x20
    wfi_addr = 32'h20;
    redirect = 1'b1;
    redirect_pc = 32'h20;
    cycle();
    cycle();
    nreq = 0;
    repeat (10) begin
      cycle();
      nreq += 32'(instr_req);
    end
`ifdef FETCH_WFI_EN
    chk("wfi_no_req", 32'(nreq), 32'd0);
    chk("wfi_sleeping", 32'(wfi_sleep), 32'd1);
    irq = 1'b1;
    cycle();
    chk("wake_req", 32'(instr_req), 32'd1);
    chk("wake_addr", instr_addr, 32'h24);
`else
    chk("nowfi_req", 32'(nreq), 32'd10);
    chk("nowfi_sleep", 32'(wfi_sleep), 32'd0);
`endif
    wfi_addr = 32'h1;

    // random traffic, reset in the middle of it
    lat_min = 0; lat_max = 3; ready_pct = 60; redir_pct = 5; irq_pct = 10; wfi_pct = 3;
    repeat (40) cycle();
    do_reset();
    ready_pct = 30;
    repeat (1500) cycle();
    ready_pct = 85;
    repeat (1500) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Parametrised instruction prefetch unit that sits between the instruction memory port and the decode/control stage of the processor core. It issues sequential word fetches with a single outstanding request, buffers returned instructions together with their PC in a DEPTH-entry FIFO, and supports flushing and redirecting on taken branches and jumps. Fetching halts after a WFI instruction and resumes on an interrupt.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  in  1  clock, rising edge
- res  in  1  asynchronous active-low reset
- instr_req  out  1  fetch request; registered
- instr_addr  out  32  fetch address; registered; stable while instr_req=1
- instr_valid  in  1  response strobe; completes the outstanding request
- instr_read  in  32  returned instruction; sampled when instr_valid=1
- out_valid  out  1  FIFO head valid
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_ready  in  1  consumer pops the head when out_valid=1 and out_ready=1
- redirect  in  1  flush and refetch; one-cycle pulse
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- irq  in  1  interrupt pending; wakes the unit from WFI
- wfi_sleep  out  1  high while the unit is halted in WFI

## Operation
- States:
  - FETCH: request issue enabled.
  - DRAIN: a request is outstanding and its response must be discarded.
  - WFI: no requests are issued.
- Issue rule:
  - In FETCH, instr_req is raised when no request is outstanding and (count + 1) ≤ DEPTH.
  - The slot is reserved at issue, so a response is never dropped for lack of space.
- Response handling (instr_valid=1 in FETCH):
  - Push {instr_read, instr_addr} into the FIFO.
  - Advance fetch_pc by 4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
- Back-to-back issue: at the completing edge, instr_req stays 1 with the next address if all of the following hold:
  - space remains after the push and any simultaneous pop;
  - the pushed word is not WFI;
  - redirect=0.
- Redirect:
  - FIFO is cleared and fetch_pc is loaded from {redirect_pc[31:2], 2'b00}.
  - If a request is outstanding and instr_valid=0 in that cycle: go to DRAIN. instr_req and instr_addr are held until instr_valid, the response is discarded, then return to FETCH.
  - If instr_valid=1 in the same cycle: the response is discarded and the next request targets redirect_pc.
  - A pop in the same cycle is ignored; redirect wins.
- WFI (32'h1050_0073), with FETCH_WFI_EN defined:
  - The WFI word is pushed like any other instruction, then the unit enters WFI and asserts wfi_sleep.
  - irq=1 in WFI: return to FETCH at WFI_pc+4.
  - redirect in WFI: return to FETCH at redirect_pc. If irq and redirect are both 1, redirect wins.
  - irq outside WFI is ignored.
  - The FIFO continues to drain while the unit is in WFI.
- Second redirect during DRAIN: the new target replaces the pending one and the unit stays in DRAIN until the response arrives.

## Timing
- Reset values while res=0:
  - instr_req=0, instr_addr=RESET_PC
  - out_valid=0, out_instr=0, out_pc=0
  - wfi_sleep=0, count=0, state FETCH
- First instr_req=1 on the first rising edge after res deasserts.
- Latency: instr_valid in cycle k → entry at the head with out_valid=1 in cycle k+1 when the FIFO was empty.
- Throughput: one instruction per cycle if memory answers in the same cycle as instr_req and the consumer pops every cycle.
- Full FIFO (count=DEPTH): instr_req=0. A pop while full permits issue in the following cycle.
- Push and pop in the same cycle: count unchanged.
- Redirect in cycle k: out_valid=0 in cycle k+1. When not draining, instr_addr=redirect_pc with instr_req=1 in cycle k+1.
- Reset asserted mid-operation: all state is cleared immediately and any outstanding response is forgotten.

## Configuration
- FETCH_WFI_EN defined: WFI detection and the WFI state as described above; wfi_sleep is functional.
- FETCH_WFI_EN undefined: WFI is treated as an ordinary instruction, irq is ignored, and wfi_sleep is tied to 0.

## Test plan
- Reset release, memory responds in the same cycle with 32'h0000_0013 on every fetch, out_ready=1 → addresses 0,4,8,… on consecutive cycles; out_pc follows one cycle behind; no bubbles.
- DEPTH=4, out_ready=0 → exactly 4 fetches, then instr_req=0. A single pop → one more fetch at 32'h10.
- Redirect to 32'h0000_0103 while a request to 32'h8 is outstanding with a 3-cycle response delay → instr_addr holds 32'h8 until valid, the response is dropped, the next request goes to 32'h100, and out_valid=0 throughout.
- Redirect and instr_valid in the same cycle, plus a pop → FIFO empty, next instr_addr equals redirect_pc.
- With FETCH_WFI_EN: word 32'h1050_0073 fetched at 32'h20 → wfi_sleep=1 with no requests for 10 cycles; irq pulse → next instr_addr=32'h24. Without FETCH_WFI_EN, the same stimulus gives continuous fetching.
- Fetch at 32'hFFFF_FFFC → next instr_addr=32'h0000_0000.
